// File: rtl/dualmem_be.sv
// True-dual-port byte-enabled RAM on a single clock, with selectable read-during-write
// behaviour, optional output register and a post-reset zeroing sequencer.
module dualmem_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLEAR_INIT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [DATA_WIDTH/8-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]     addra,
    input  logic [DATA_WIDTH-1:0]     dina,
    output logic [DATA_WIDTH-1:0]     douta,
    output logic                      valida,
    input  logic                      enb,
    input  logic [DATA_WIDTH/8-1:0]   web,
    input  logic [ADDR_WIDTH-1:0]     addrb,
    input  logic [DATA_WIDTH-1:0]     dinb,
    output logic [DATA_WIDTH-1:0]     doutb,
    output logic                      validb,
    output logic                      busy
);

    localparam int NBE   = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CTR_LAST = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NBE-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NBE; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                          input logic [DATA_WIDTH-1:0] new_w,
                                                          input logic [NBE-1:0]        be);
        logic [DATA_WIDTH-1:0] m;
        m = lane_mask(be);
        return (old_w & ~m) | (new_w & m);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_d, state_q;
    logic [ADDR_WIDTH-1:0] ctr_d, ctr_q;
    logic                  clr_we_s;

    logic                  ena_s, enb_s, same_addr_s;
    logic [NBE-1:0]        wa_lane_s, wb_lane_s;
    logic [NBE-1:0]        pa_mask_s, pb_mask_s;
    logic [DATA_WIDTH-1:0] pa_data_s, pb_data_s;

    logic                  va1_d, va1_q, vb1_d, vb1_q;
    logic [NBE-1:0]        pa_mask_d, pa_mask_q, pb_mask_d, pb_mask_q;
    logic [DATA_WIDTH-1:0] pa_data_d, pa_data_q, pb_data_d, pb_data_q;
    logic [DATA_WIDTH-1:0] rda_q, rdb_q;
    logic [DATA_WIDTH-1:0] data1a_s, data1b_s;

    assign busy     = (state_q == ST_CLEAR);
    assign clr_we_s = (state_q == ST_CLEAR) & ~rst;

    // Clear sequencer: walks every word once, then parks in IDLE until the next reset
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ctr_q == CTR_LAST) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else begin
                    state_d = ST_CLEAR;
                    ctr_d   = ctr_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
                ctr_d   = ctr_q;
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_IDLE;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Access qualification and collision arbitration: A owns contested lanes.
    // The *_mask/_data pair describes the post-write word a writing port must see.
    always_comb begin
        ena_s       = ena & ~busy & ~rst;
        enb_s       = enb & ~busy & ~rst;
        same_addr_s = (addra == addrb);
        if (ena_s) begin
            wa_lane_s = wea;
        end else begin
            wa_lane_s = '0;
        end
        if (enb_s) begin
            wb_lane_s = web & ~(same_addr_s ? wa_lane_s : {NBE{1'b0}});
        end else begin
            wb_lane_s = '0;
        end
        if (ena_s && (|wea)) begin
            pa_mask_s = wa_lane_s | (same_addr_s ? wb_lane_s : {NBE{1'b0}});
            pa_data_s = (dina & lane_mask(wa_lane_s))
                      | (dinb & lane_mask(same_addr_s ? wb_lane_s : {NBE{1'b0}}));
        end else begin
            pa_mask_s = '0;
            pa_data_s = '0;
        end
        if (enb_s && (|web)) begin
            pb_mask_s = wb_lane_s | (same_addr_s ? wa_lane_s : {NBE{1'b0}});
            pb_data_s = (dinb & lane_mask(wb_lane_s))
                      | (dina & lane_mask(same_addr_s ? wa_lane_s : {NBE{1'b0}}));
        end else begin
            pb_mask_s = '0;
            pb_data_s = '0;
        end
    end

    // Storage write path: zeroing has priority, otherwise per-lane port writes
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[ctr_q] <= '0;
        end else begin
            for (int i = 0; i < NBE; i++) begin
                if (wa_lane_s[i]) mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
                if (wb_lane_s[i]) mem_q[addrb][8*i +: 8] <= dinb[8*i +: 8];
            end
        end
    end

    // Synchronous read registers; they hold while the port is idle so dout holds too
    always_ff @(posedge clk) begin
        if (rst) begin
            rda_q <= '0;
            rdb_q <= '0;
        end else begin
            if (ena_s) rda_q <= mem_q[addra];
            if (enb_s) rdb_q <= mem_q[addrb];
        end
    end

    // First pipeline stage next-state: valid follows the enable, write info held with the read
    always_comb begin
        va1_d = ena_s;
        vb1_d = enb_s;
        if (ena_s) begin
            pa_mask_d = pa_mask_s;
            pa_data_d = pa_data_s;
        end else begin
            pa_mask_d = pa_mask_q;
            pa_data_d = pa_data_q;
        end
        if (enb_s) begin
            pb_mask_d = pb_mask_s;
            pb_data_d = pb_data_s;
        end else begin
            pb_mask_d = pb_mask_q;
            pb_data_d = pb_data_q;
        end
    end

    // First pipeline stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            va1_q     <= 1'b0;
            vb1_q     <= 1'b0;
            pa_mask_q <= '0;
            pa_data_q <= '0;
            pb_mask_q <= '0;
            pb_data_q <= '0;
        end else begin
            va1_q     <= va1_d;
            vb1_q     <= vb1_d;
            pa_mask_q <= pa_mask_d;
            pa_data_q <= pa_data_d;
            pb_mask_q <= pb_mask_d;
            pb_data_q <= pb_data_d;
        end
    end

    assign data1a_s = (RDW_MODE != 0) ? merge_lanes(rda_q, pa_data_q, pa_mask_q) : rda_q;
    assign data1b_s = (RDW_MODE != 0) ? merge_lanes(rdb_q, pb_data_q, pb_mask_q) : rdb_q;

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] douta2_d, douta2_q, doutb2_d, doutb2_q;
        logic                  valida2_d, valida2_q, validb2_d, validb2_q;

        // Output stage loads only on a valid first-stage word
        always_comb begin
            valida2_d = va1_q;
            validb2_d = vb1_q;
            if (va1_q) begin
                douta2_d = data1a_s;
            end else begin
                douta2_d = douta2_q;
            end
            if (vb1_q) begin
                doutb2_d = data1b_s;
            end else begin
                doutb2_d = doutb2_q;
            end
        end

        // Output register stage
        always_ff @(posedge clk) begin
            if (rst) begin
                douta2_q  <= '0;
                doutb2_q  <= '0;
                valida2_q <= 1'b0;
                validb2_q <= 1'b0;
            end else begin
                douta2_q  <= douta2_d;
                doutb2_q  <= doutb2_d;
                valida2_q <= valida2_d;
                validb2_q <= validb2_d;
            end
        end

        assign douta  = douta2_q;
        assign doutb  = doutb2_q;
        assign valida = valida2_q;
        assign validb = validb2_q;
    end else begin : g_noreg
        assign douta  = data1a_s;
        assign doutb  = data1b_s;
        assign valida = va1_q;
        assign validb = vb1_q;
    end

endmodule

// File: tb/tb_dualmem_be.sv
// Scoreboard bench for dualmem_be: two instances (registered/read-first and
// unregistered/write-first) share one directed stimulus stream.
module tb_dualmem_be;

    logic        clk = 1'b0;
    logic        rst, ena, enb;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] douta0, doutb0, douta1, doutb1;
    logic        valida0, validb0, valida1, validb1, busy0, busy1;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        q[4][$];
    string       pn[4] = '{"a_rf", "b_rf", "a_wf", "b_wf"};
    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          nb0, nb1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dualmem_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .RDW_MODE(0), .CLEAR_INIT(1)) dut0 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .valida(valida0),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .validb(validb0),
        .busy(busy0));

    dualmem_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(1), .CLEAR_INIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .valida(valida1),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .validb(validb1),
        .busy(busy1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        if (v === 1'b1) begin
            if (q[p].size() == 0) begin
                n_total++;
                $display("FAIL %s_unexpected: got valid=1 expected valid=0 (data 0x%08h)", pn[p], d);
            end else begin
                e = q[p].pop_front();
                chk({pn[p], "_data"}, d, e.data);
                chk({pn[p], "_latency"}, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, valida0, douta0);
        mon(1, validb0, doutb0);
        mon(2, valida1, douta1);
        mon(3, validb1, doutb1);
    end

    // One access cycle on both ports; rf = read-first/2-cycle DUT, wf = write-first/1-cycle DUT
    task automatic step(input logic a_en, input logic [3:0] a_we, input logic [3:0] a_ad,
                        input logic [31:0] a_d, input logic [31:0] a_rf, input logic [31:0] a_wf,
                        input logic b_en, input logic [3:0] b_we, input logic [3:0] b_ad,
                        input logic [31:0] b_d, input logic [31:0] b_rf, input logic [31:0] b_wf);
        ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
        enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
        if (a_en) begin
            q[0].push_back('{data: a_rf, cyc: cyc + 2});
            q[2].push_back('{data: a_wf, cyc: cyc + 1});
        end
        if (b_en) begin
            q[1].push_back('{data: b_rf, cyc: cyc + 2});
            q[3].push_back('{data: b_wf, cyc: cyc + 1});
        end
        @(posedge clk); #1;
        ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    endtask

    task automatic wa(input logic [3:0] ad, input logic [3:0] we, input logic [31:0] d,
                      input logic [31:0] rf, input logic [31:0] wf);
        step(1'b1, we, ad, d, rf, wf, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic ra(input logic [3:0] ad, input logic [31:0] e);
        step(1'b1, 4'h0, ad, 32'h0, e, e, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic rb(input logic [3:0] ad, input logic [31:0] e);
        step(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h0, ad, 32'h0, e, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Counts cycles with busy high; optionally fires a port-A write (to word 2) at cycle inj
    task automatic count_busy(input int inj, output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 100 && (busy0 || busy1); k++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (k == inj) begin
                ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'hFFFF_FFFF;
            end else begin
                ena = 1'b0; wea = 4'h0;
            end
            @(posedge clk); #1;
        end
        ena = 1'b0; wea = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
        addra = 4'h0; addrb = 4'h0; dina = 32'h0; dinb = 32'h0;
        @(posedge clk); #1;

        // reset state and clear sequence length
        do_reset();
        chk("rst_douta0", douta0, 32'h0);
        chk("rst_doutb1", doutb1, 32'h0);
        chk("rst_valid", {28'h0, valida0, validb0, valida1, validb1}, 32'h0);
        chk("rst_busy", {30'h0, busy0, busy1}, 32'h3);
        count_busy(-1, nb0, nb1);
        chk("busy_cycles0", nb0, 32'd16);
        chk("busy_cycles1", nb1, 32'd16);

        // every word zero, both ports back-to-back
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'h0, 4'(i), 32'h0, 32'h0, 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0, 32'h0, 32'h0);

        // A write then B read of the same word
        wa(4'd5, 4'hF, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
        rb(4'd5, 32'hDEAD_BEEF);
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_douta0", douta0, 32'h0);
        chk("hold_douta1", douta1, 32'hDEAD_BEEF);
        chk("hold_doutb0", doutb0, 32'hDEAD_BEEF);
        chk("hold_valid", {28'h0, valida0, validb0, valida1, validb1}, 32'h0);

        // byte-lane partial write
        wa(4'd7, 4'hF, 32'h1122_3344, 32'h0, 32'h1122_3344);
        wa(4'd7, 4'b0101, 32'hAABB_CCDD, 32'h1122_3344, 32'h11BB_33DD);
        ra(4'd7, 32'h11BB_33DD);

        // same-port read-during-write
        wa(4'd3, 4'hF, 32'h0000_0077, 32'h0, 32'h0000_0077);
        wa(4'd3, 4'hF, 32'h0000_0055, 32'h0000_0077, 32'h0000_0055);
        rb(4'd3, 32'h0000_0055);

        // cross-port collisions
        step(1'b1, 4'b0011, 4'd9, 32'hAAAA_AAAA, 32'h0, 32'hBBBB_AAAA,
             1'b1, 4'b1111, 4'd9, 32'hBBBB_BBBB, 32'h0, 32'hBBBB_AAAA);
        step(1'b1, 4'hF, 4'd9, 32'hCCCC_CCCC, 32'hBBBB_AAAA, 32'hCCCC_CCCC,
             1'b1, 4'h0, 4'd9, 32'h0, 32'hBBBB_AAAA, 32'hBBBB_AAAA);
        rb(4'd9, 32'hCCCC_CCCC);
        step(1'b1, 4'hF, 4'd1, 32'h1234_5678, 32'h0, 32'h1234_5678,
             1'b1, 4'hF, 4'd2, 32'h9ABC_DEF0, 32'h0, 32'h9ABC_DEF0);
        step(1'b1, 4'h0, 4'd2, 32'h0, 32'h9ABC_DEF0, 32'h9ABC_DEF0,
             1'b1, 4'h0, 4'd1, 32'h0, 32'h1234_5678, 32'h1234_5678);
        repeat (4) begin @(posedge clk); #1; end

        // reset mid-clear restarts the full sequence; access while busy is ignored
        do_reset();
        chk("rst2_doutb0", doutb0, 32'h0);
        chk("rst2_douta1", douta1, 32'h0);
        repeat (8) begin @(posedge clk); #1; end
        chk("midclear_busy", {30'h0, busy0, busy1}, 32'h3);
        do_reset();
        count_busy(12, nb0, nb1);
        chk("restart_busy0", nb0, 32'd16);
        chk("restart_busy1", nb1, 32'd16);
        ra(4'd5, 32'h0);
        rb(4'd7, 32'h0);
        ra(4'd3, 32'h0);
        rb(4'd9, 32'h0);
        ra(4'd2, 32'h0);
        rb(4'd1, 32'h0);
        repeat (4) begin @(posedge clk); #1; end

        for (int p = 0; p < 4; p++) chk({pn[p], "_drained"}, q[p].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
